// File: rtl/exu_mul_arb_if.sv
// Request, multiplier-issue and response bundle for exu_mul_arb.
// slave  : the arbiter side (takes requests, drives the multiplier and responses).
// master : the environment side (requesters and the multiplier itself).
interface exu_mul_arb_if #(
    parameter int TAG_W = 2
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic             req0_rs1_sign;
    logic             req0_rs2_sign;
    logic             req0_low;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic             req1_rs1_sign;
    logic             req1_rs2_sign;
    logic             req1_low;
    logic [TAG_W-1:0] req1_tag;

    logic             mul_valid;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_rs1_sign;
    logic             mul_rs2_sign;
    logic             mul_low;
    logic [31:0]      mul_result;

    logic             resp0_valid;
    logic [TAG_W-1:0] resp0_tag;
    logic [31:0]      resp0_data;
    logic             resp1_valid;
    logic [TAG_W-1:0] resp1_tag;
    logic [31:0]      resp1_data;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_rs1_sign, req0_rs2_sign, req0_low, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low, req1_tag,
        output req0_ready, req1_ready,
        output mul_valid, mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low,
        input  mul_result,
        output resp0_valid, resp0_tag, resp0_data,
        output resp1_valid, resp1_tag, resp1_data
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_rs1_sign, req0_rs2_sign, req0_low, req0_tag,
        output req1_valid, req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low, req1_tag,
        input  req0_ready, req1_ready,
        input  mul_valid, mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low,
        output mul_result,
        input  resp0_valid, resp0_tag, resp0_data,
        input  resp1_valid, resp1_tag, resp1_data
    );
endinterface

// File: rtl/exu_mul_arb.sv
// exu_mul_arb: shares one LAT-stage pipelined multiplier between the decode
// mul path (port 0, high priority) and the VP verify path (port 1).
// Owner and tag of every issued op ride a shift register alongside the
// multiplier so the result can be steered back to the right port.
// Optional: EXU_MUL_ARB_STARVE_EN adds a port-1 anti-starvation counter.
module exu_mul_arb #(
    parameter int LAT        = 3,
    parameter int TAG_W      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic            flush,
    exu_mul_arb_if.slave    bus,
    output logic            busy
);

    logic             rst_dly_q;
    logic             elig;
    logic             force1;
    logic             gnt0;
    logic             gnt1;

    logic [LAT-1:0]   vld_q, vld_d;
    logic [LAT-1:0]   own_q, own_d;
    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] tag_d [LAT];
    logic [LAT-1:0]   keep;

    logic             fire;
    logic             fire0;
    logic             fire1;

`ifdef EXU_MUL_ARB_STARVE_EN
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    logic [2:0] starve_q, starve_d;

    // Count port-1 losses, saturating; any port-1 grant clears it.
    always_comb begin
        starve_d = starve_q;
        if (gnt1)
            starve_d = 3'd0;
        else if (!freeze && bus.req1_valid && (starve_q != STARVE_LIM))
            starve_d = starve_q + 3'd1;
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) starve_q <= 3'd0;
        else     starve_q <= starve_d;
    end

    assign force1 = (starve_q == STARVE_LIM) && bus.req1_valid;
`else
    assign force1 = 1'b0;
`endif

    // Remember reset for one cycle so grants stay off in the cycle after it.
    always_ff @(posedge clk) begin
        rst_dly_q <= rst;
    end

    // Combinational grant: port 0 first unless flushed or port 1 is being forced.
    always_comb begin
        elig = !freeze && !rst && !rst_dly_q;
        gnt0 = elig && bus.req0_valid && !flush && !force1;
        gnt1 = elig && bus.req1_valid && !gnt0;
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.mul_valid  = gnt0 | gnt1;

    // Issue packet mux; zero when nothing is granted.
    always_comb begin
        bus.mul_a        = 32'd0;
        bus.mul_b        = 32'd0;
        bus.mul_rs1_sign = 1'b0;
        bus.mul_rs2_sign = 1'b0;
        bus.mul_low      = 1'b0;
        if (gnt0) begin
            bus.mul_a        = bus.req0_a;
            bus.mul_b        = bus.req0_b;
            bus.mul_rs1_sign = bus.req0_rs1_sign;
            bus.mul_rs2_sign = bus.req0_rs2_sign;
            bus.mul_low      = bus.req0_low;
        end else if (gnt1) begin
            bus.mul_a        = bus.req1_a;
            bus.mul_b        = bus.req1_b;
            bus.mul_rs1_sign = bus.req1_rs1_sign;
            bus.mul_rs2_sign = bus.req1_rs2_sign;
            bus.mul_low      = bus.req1_low;
        end
    end

    // Tracking next state: flush kills port-0 entries even while frozen;
    // otherwise the pipe shifts and stage LAT retires off the end.
    always_comb begin
        keep  = vld_q & (own_q | {LAT{~flush}});
        vld_d = keep;
        own_d = own_q;
        tag_d = tag_q;
        if (!freeze) begin
            vld_d[0] = gnt0 | gnt1;
            own_d[0] = gnt1;
            tag_d[0] = gnt1 ? bus.req1_tag : (gnt0 ? bus.req0_tag : '0);
            for (int i = 1; i < LAT; i++) begin
                vld_d[i] = keep[i-1];
                own_d[i] = own_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    // Tracking register; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            own_q <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
            for (int i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
        end
    end

    // Response steering from the last stage; idle port drives zeros.
    always_comb begin
        fire  = vld_q[LAT-1] && !freeze && !rst;
        fire0 = fire && !own_q[LAT-1] && !flush;
        fire1 = fire && own_q[LAT-1];
        bus.resp0_valid = fire0;
        bus.resp0_tag   = fire0 ? tag_q[LAT-1] : '0;
        bus.resp0_data  = fire0 ? bus.mul_result : 32'd0;
        bus.resp1_valid = fire1;
        bus.resp1_tag   = fire1 ? tag_q[LAT-1] : '0;
        bus.resp1_data  = fire1 ? bus.mul_result : 32'd0;
    end

    assign busy = (|vld_q) && !rst;

endmodule

// File: tb/tb_exu_mul_arb.sv
module tb_exu_mul_arb;
    localparam int LAT        = 3;
    localparam int TAG_W      = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic freeze = 1'b0;
    logic flush = 1'b0;
    logic busy;

    int total = 0;
    int bad   = 0;

    exu_mul_arb_if #(.TAG_W(TAG_W)) bus();

    exu_mul_arb #(.LAT(LAT), .TAG_W(TAG_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .flush  (flush),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb, input logic low);
        logic [63:0] x, y, p;
        x = sa ? {{32{a[31]}}, a} : {32'd0, a};
        y = sb ? {{32{b[31]}}, b} : {32'd0, b};
        p = x * y;
        return low ? p[31:0] : p[63:32];
    endfunction

    // Multiplier stand-in: fixed LAT-stage pipe that holds under freeze.
    logic [31:0] mp [LAT];
    initial for (int i = 0; i < LAT; i++) mp[i] = 32'd0;
    always @(posedge clk) begin
        if (!freeze) begin
            mp[0] <= bus.mul_valid ? mul_ref(bus.mul_a, bus.mul_b, bus.mul_rs1_sign,
                                             bus.mul_rs2_sign, bus.mul_low) : 32'd0;
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end
    assign bus.mul_result = mp[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit              port;
        logic [TAG_W-1:0] tag;
        logic [31:0]     data;
        int              cnt;
    } ent_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } rsp_t;

    ent_t infl [$];
    rsp_t exp0 [$];
    rsp_t exp1 [$];
    int   starve  = 0;
    bit   rst_prev = 1'b0;

    always @(negedge clk) begin
        bit elig, force1, g0, g1;
        logic [34:0] mexp, mact;
        ent_t e;

        check("busy", {63'd0, busy}, {63'd0, (!rst && infl.size() != 0)});

        elig   = !rst && !rst_prev && !freeze;
        force1 = 1'b0;
`ifdef EXU_MUL_ARB_STARVE_EN
        force1 = (starve >= STARVE_MAX) && bus.req1_valid;
`endif
        g0 = elig && bus.req0_valid && !flush && !force1;
        g1 = elig && bus.req1_valid && !g0;

        check("grant", {61'd0, bus.req0_ready, bus.req1_ready, bus.mul_valid},
              {61'd0, g0, g1, (g0 || g1)});
        if (g0)      mexp = {bus.req0_a, bus.req0_rs1_sign, bus.req0_rs2_sign, bus.req0_low};
        else if (g1) mexp = {bus.req1_a, bus.req1_rs1_sign, bus.req1_rs2_sign, bus.req1_low};
        else         mexp = '0;
        mact = {bus.mul_a, bus.mul_rs1_sign, bus.mul_rs2_sign, bus.mul_low};
        check("mul_pkt", {29'd0, mact}, {29'd0, mexp});
        check("mul_b", {32'd0, bus.mul_b},
              {32'd0, g0 ? bus.req0_b : (g1 ? bus.req1_b : 32'd0)});

        if (rst) begin
            infl.delete();
        end else begin
            if (flush)
                for (int i = infl.size() - 1; i >= 0; i--)
                    if (infl[i].port == 1'b0) infl.delete(i);
            if (!freeze && infl.size() != 0 && infl[0].cnt == 0) begin
                if (infl[0].port) exp1.push_back('{infl[0].tag, infl[0].data});
                else              exp0.push_back('{infl[0].tag, infl[0].data});
                infl.delete(0);
            end
            if (g0) begin
                e.port = 1'b0; e.tag = bus.req0_tag; e.cnt = LAT;
                e.data = mul_ref(bus.req0_a, bus.req0_b, bus.req0_rs1_sign,
                                 bus.req0_rs2_sign, bus.req0_low);
                infl.push_back(e);
            end else if (g1) begin
                e.port = 1'b1; e.tag = bus.req1_tag; e.cnt = LAT;
                e.data = mul_ref(bus.req1_a, bus.req1_b, bus.req1_rs1_sign,
                                 bus.req1_rs2_sign, bus.req1_low);
                infl.push_back(e);
            end
            if (!freeze)
                for (int i = 0; i < infl.size(); i++) infl[i].cnt--;
        end

`ifdef EXU_MUL_ARB_STARVE_EN
        if (rst || g1)                                                  starve = 0;
        else if (!freeze && bus.req1_valid && starve < STARVE_MAX)      starve++;
`endif
        rst_prev = rst;
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        rsp_t r;
        #1;
        if (bus.resp0_valid) begin
            if (exp0.size() == 0) begin
                check("resp0_unexpected", 64'd1, 64'd0);
            end else begin
                r = exp0.pop_front();
                check("resp0_tag",  {62'd0, bus.resp0_tag}, {62'd0, r.tag});
                check("resp0_data", {32'd0, bus.resp0_data}, {32'd0, r.data});
            end
        end else begin
            if (exp0.size() != 0) begin
                check("resp0_missing", 64'd0, 64'd1);
                exp0.delete();
            end
            check("resp0_idle", {30'd0, bus.resp0_tag, bus.resp0_data}, 64'd0);
        end
        if (bus.resp1_valid) begin
            if (exp1.size() == 0) begin
                check("resp1_unexpected", 64'd1, 64'd0);
            end else begin
                r = exp1.pop_front();
                check("resp1_tag",  {62'd0, bus.resp1_tag}, {62'd0, r.tag});
                check("resp1_data", {32'd0, bus.resp1_data}, {32'd0, r.data});
            end
        end else begin
            if (exp1.size() != 0) begin
                check("resp1_missing", 64'd0, 64'd1);
                exp1.delete();
            end
            check("resp1_idle", {30'd0, bus.resp1_tag, bus.resp1_data}, 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_ops();
        bus.req0_a = $urandom; bus.req0_b = $urandom;
        bus.req1_a = $urandom; bus.req1_b = $urandom;
        {bus.req0_rs1_sign, bus.req0_rs2_sign, bus.req0_low} = 3'($urandom);
        {bus.req1_rs1_sign, bus.req1_rs2_sign, bus.req1_low} = 3'($urandom);
        bus.req0_tag = TAG_W'($urandom);
        bus.req1_tag = TAG_W'($urandom);
    endtask

    task automatic cyc(input logic r0v, input logic r1v, input logic fz,
                       input logic fl, input logic rs, input int n);
        for (int k = 0; k < n; k++) begin
            rand_ops();
            bus.req0_valid = r0v;
            bus.req1_valid = r1v;
            freeze = fz;
            flush  = fl;
            rst    = rs;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rand_ops();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        cyc(1, 1, 0, 0, 1, 3);          // reset with requests pending
        cyc(0, 0, 0, 0, 0, 2);

        // single op 7*6 low, tag 2
        rand_ops();
        bus.req0_a = 32'd7; bus.req0_b = 32'd6;
        bus.req0_rs1_sign = 1'b0; bus.req0_rs2_sign = 1'b0; bus.req0_low = 1'b1;
        bus.req0_tag = 2'd2;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
        freeze = 1'b0; flush = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 0, 5);

        // contention
        cyc(1, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 5);

        // freeze holds the pipe and blocks grants
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 2);
        cyc(0, 0, 0, 0, 0, 5);

        // flush kills port-0 entries only
        cyc(1, 0, 0, 0, 0, 2);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 5);

        // flush together with freeze
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 5);

        // continuous contention (starvation path when enabled)
        cyc(1, 1, 0, 0, 0, 12);
        cyc(0, 0, 0, 0, 0, 5);

        // reset mid-flight
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 5);

        // randomized traffic
        for (int k = 0; k < 3000; k++)
            cyc(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 6),
                ($urandom_range(0, 99) < 1), 1);

        cyc(0, 0, 0, 0, 0, 10);
        @(negedge clk); #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
